// File: rtl/serdes_pkg.sv
// Shared definitions for the byte-lane serializer/deserializer pair:
// default geometry, frame length and the framing state encoding.
package serdes_pkg;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_NBYTES = 4;
  localparam int FRAME_LEN  = DEF_NBYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / byte-out bundle for the serializer. The slave side is the block;
// the master side is the word source and the byte-lane observer.
interface word_serializer_if
  import serdes_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int NBYTES = DEF_NBYTES
);
  localparam int WORD_W = BYTE_W * NBYTES;

  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_ready;
  logic              Cout;
  logic [BYTE_W-1:0] Dout;
  logic              Vout;
  logic              Done;
  logic              busy;

  modport master (output s_valid, s_data,
                  input  s_ready, Cout, Dout, Vout, Done, busy);

  modport slave  (input  s_valid, s_data,
                  output s_ready, Cout, Dout, Vout, Done, busy);

endinterface

// File: rtl/word_serializer.sv
// Serializes one word per valid/ready transfer into NBYTES bytes, MS byte first,
// with Cout on the first byte, Done on the last and IFG idle cycles between frames.
module word_serializer
  import serdes_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int NBYTES = DEF_NBYTES,
  parameter int IFG    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  word_serializer_if.slave bus
);

  localparam int                WORD_W   = BYTE_W * NBYTES;
  localparam int                CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NBYTES - 1);
  localparam logic [3:0]        GAP_LAST = 4'((IFG > 0) ? (IFG - 1) : 0);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          gap_q, gap_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic                live_q;
  logic                cout_q, cout_d;
  logic                vout_q, vout_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [BYTE_W-1:0]   dout_q, dout_d;

  logic last_byte, last_gap, s_ready_w, xfer;

  assign last_byte = (state_q == SEND) && (cnt_q == CNT_LAST);
  assign last_gap  = (state_q == GAP) && (gap_q == GAP_LAST);

  // A word may follow a frame directly only when no gap is configured.
  assign s_ready_w = live_q && ((state_q == IDLE) || (last_byte && (IFG == 0)) || last_gap);
  assign xfer      = bus.s_valid && s_ready_w;

  always_comb begin
    // NOTE: every variable gets its default first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    shift_d = shift_q;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SEND;
          shift_d = bus.s_data;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (last_byte) begin
          if (xfer) begin
            shift_d = bus.s_data;
            cnt_d   = '0;
          end else if (IFG == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = shift_q << BYTE_W;
        end
      end
      GAP: begin
        if (last_gap) begin
          if (xfer) begin
            state_d = SEND;
            shift_d = bus.s_data;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from the next state so they leave the block registered.
    vout_d = (state_d == SEND);
    cout_d = vout_d && (cnt_d == '0);
    done_d = vout_d && (cnt_d == CNT_LAST);
    dout_d = vout_d ? shift_d[WORD_W-1 -: BYTE_W] : '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      // NOTE: the datapath shift register is reset as well, so nothing stale can reach Dout.
      shift_q <= '0;
      live_q  <= 1'b0;
      cout_q  <= 1'b0;
      vout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      live_q  <= 1'b1;
      cout_q  <= cout_d;
      vout_q  <= vout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.s_ready = s_ready_w;
  assign bus.Cout    = cout_q;
  assign bus.Vout    = vout_q;
  assign bus.Done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.Dout    = dout_q;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: one serializer without and one with a 2-cycle gap, compared
// cycle by cycle against a schedule of expected output slots built per accepted word.
module tb_word_serializer;
  import serdes_pkg::*;

  typedef struct packed {
    logic       vout;
    logic       cout;
    logic       done;
    logic [7:0] dout;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  word_serializer_if #(.BYTE_W(8), .NBYTES(4)) bus0 ();
  word_serializer_if #(.BYTE_W(8), .NBYTES(4)) bus2 ();

  word_serializer #(.BYTE_W(8), .NBYTES(4), .IFG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  word_serializer #(.BYTE_W(8), .NBYTES(4), .IFG(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic        valid_r [2];
  logic [31:0] data_r  [2];

  assign bus0.s_valid = valid_r[0];
  assign bus0.s_data  = data_r[0];
  assign bus2.s_valid = valid_r[1];
  assign bus2.s_data  = data_r[1];

  // Expected future output slots per DUT; slot 0 is what the current cycle must show.
  slot_t sched [2][16];
  int    cnt   [2];
  bit    live  [2];
  bit    xfer  [2];
  int    checks = 0;
  int    errors = 0;

  function automatic int ifg_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample(input int d, output slot_t s, output logic rdy, output logic bsy);
    if (d == 0) begin
      s = '{bus0.Vout, bus0.Cout, bus0.Done, bus0.Dout};
      rdy = bus0.s_ready;
      bsy = bus0.busy;
    end else begin
      s = '{bus2.Vout, bus2.Cout, bus2.Done, bus2.Dout};
      rdy = bus2.s_ready;
      bsy = bus2.busy;
    end
  endtask

  task automatic push_frame(input int d, input logic [31:0] w);
    for (int i = 0; i < FRAME_LEN; i++) begin
      slot_t s;
      s.vout = 1'b1;
      s.cout = (i == 0);
      s.done = (i == FRAME_LEN - 1);
      s.dout = 8'(w >> (8 * (FRAME_LEN - 1 - i)));
      sched[d][cnt[d]] = s;
      cnt[d]++;
    end
    for (int i = 0; i < ifg_of(d); i++) begin
      sched[d][cnt[d]] = '0;
      cnt[d]++;
    end
  endtask

  task automatic pop_slot(input int d);
    for (int i = 0; i < 15; i++) sched[d][i] = sched[d][i+1];
    cnt[d]--;
  endtask

  // One clock cycle: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      slot_t exp_s, obs;
      logic  rdy, bsy;
      bit    exp_rdy;
      string p;
      p       = $sformatf("d%0d_", d);
      exp_s   = (cnt[d] > 0) ? sched[d][0] : '0;
      exp_rdy = live[d] && rst_n && (cnt[d] <= 1);
      sample(d, obs, rdy, bsy);
      check({p, "vout"},  obs.vout, exp_s.vout);
      check({p, "cout"},  obs.cout, exp_s.cout);
      check({p, "done"},  obs.done, exp_s.done);
      check({p, "dout"},  obs.dout, exp_s.dout);
      check({p, "busy"},  bsy, cnt[d] > 0);
      check({p, "ready"}, rdy, exp_rdy);
      xfer[d] = valid_r[d] && exp_rdy;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        if (cnt[d] > 0) pop_slot(d);
        if (xfer[d]) push_frame(d, data_r[d]);
        live[d] = 1'b1;
      end
    end
    #1;
  endtask

  // Hold a word until the DUT takes it, then scramble the source data.
  task automatic send(input int d, input logic [31:0] w);
    bit taken = 1'b0;
    valid_r[d] = 1'b1;
    data_r[d]  = w;
    for (int n = 0; n < 40 && !taken; n++) begin
      step();
      if (xfer[d]) taken = 1'b1;
    end
    check($sformatf("d%0d_accepted", d), taken, 1'b1);
    valid_r[d] = 1'b0;
    data_r[d]  = $urandom;
  endtask

  // Reset asserted between clock edges: outputs must clear without waiting for a clock.
  task automatic reset_abort();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      slot_t obs;
      logic  rdy, bsy;
      sample(d, obs, rdy, bsy);
      check($sformatf("d%0d_async_outs", d), {obs, rdy, bsy}, '0);
      cnt[d]  = 0;
      live[d] = 1'b0;
      xfer[d] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid_r[d] = 1'b1;
      data_r[d]  = $urandom;
      cnt[d]     = 0;
      live[d]    = 1'b0;
      xfer[d]    = 1'b0;
    end
    #1 rst_n = 1'b0;

    // Reset with s_valid high: everything quiet, nothing taken.
    repeat (3) step();
    valid_r[0] = 1'b0;
    valid_r[1] = 1'b0;
    rst_n = 1'b1;
    repeat (2) step();

    // Single word, then back-to-back pair without gap.
    send(0, 32'hA1B2C3D4);
    repeat (6) step();
    send(0, 32'h11223344);
    send(0, 32'h55667788);
    repeat (6) step();

    // Two words through the gapped instance.
    send(1, 32'hDEADBEEF);
    send(1, 32'h01020304);
    repeat (8) step();

    // Word offered mid-frame waits for the last-byte edge.
    send(0, 32'h0F1E2D3C);
    repeat (2) step();
    send(0, 32'hCAFEF00D);
    repeat (6) step();

    // Abort after two bytes, then recover.
    send(0, 32'h0BADC0DE);
    repeat (2) step();
    reset_abort();
    repeat (2) step();
    rst_n = 1'b1;
    send(0, 32'h12345678);
    repeat (6) step();

    // Random traffic on both instances; an offered word is held until taken.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (!valid_r[d] && ($urandom_range(0, 1) == 1)) begin
          valid_r[d] = 1'b1;
          data_r[d]  = $urandom;
        end
      end
      step();
      for (int d = 0; d < 2; d++) begin
        if (xfer[d]) begin
          valid_r[d] = 1'b0;
          data_r[d]  = $urandom;
        end
      end
    end
    valid_r[0] = 1'b0;
    valid_r[1] = 1'b0;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Transmit-side counterpart of the 4-byte deserializer: takes a 32-bit word over a valid/ready handshake and emits it as a frame of 4 bytes on consecutive cycles, most significant byte first.
- Cout marks the first byte of each frame, matching the receiver's frame-start (Cin) convention.
- An optional inter-frame gap separates frames.
- Sits between the word-level datapath and the byte lane feeding the link/deserializer.

Parameters:
- BYTE_W, 8, width of one output byte
- NBYTES, 4, bytes per word; word width = NBYTES*BYTE_W
- IFG, 0, idle cycles inserted after each frame (0..15)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_data  in  NBYTES*BYTE_W  input word
- s_ready  out  1  block can accept a word this cycle
- Cout  out  1  frame start; high only with the first (MS) byte
- Dout  out  BYTE_W  output byte; 0 when Vout low
- Vout  out  1  Dout carries a valid byte
- Done  out  1  one-cycle pulse coincident with the last byte of a frame
- busy  out  1  frame or gap in progress

Behaviour:
- Reset (rst_n low, asynchronous):
  - Cout, Vout, Done, busy = 0; Dout = 0.
  - State = IDLE; shift register and counters = 0.
- s_ready during and after reset:
  - s_ready = 0 while rst_n is low.
  - s_ready stays 0 for the first cycle after deassertion, via a registered live flag.
- Transfer occurs on a clock edge where s_valid && s_ready.
- All outputs except s_ready are registered. s_ready is combinational from state, counters and the live flag.
- States:
  - IDLE: s_ready = 1 (once live).
    - Transfer -> SEND; load s_data into shift register; byte counter = 0.
  - SEND: one byte per cycle; Vout = 1.
    - Dout = shift register MS byte; shift left by BYTE_W each cycle.
    - Cout = 1 when counter = 0.
    - Done = 1 when counter = NBYTES-1.
    - At the last byte: if IFG = 0 and a transfer occurs, reload and stay in SEND with counter = 0 (back-to-back, no bubble). If IFG = 0 and no transfer -> IDLE. If IFG > 0 -> GAP.
  - GAP: Vout = 0, Dout = 0; counts IFG cycles.
    - s_ready = 1 only in the final gap cycle; a transfer there -> SEND.
    - Otherwise, after the last gap cycle -> IDLE.
- s_ready in SEND is 1 only in the last-byte cycle, and only when IFG = 0. It is 0 in all other SEND cycles.
- Latency: transfer at edge k; first byte with Cout is visible after edge k, then bytes on the following consecutive cycles. Done accompanies byte NBYTES-1, visible after edge k+NBYTES-1.
- Byte order: Dout sequence = s_data[31:24], [23:16], [15:8], [7:0] (generalised MS-first).
- busy = 1 in SEND and GAP.
- s_data is sampled only at transfer; later changes are ignored.
- s_valid while s_ready = 0: not accepted. The source must hold the word (standard valid/ready rule; the block does not buffer it).
- Reset asserted mid-frame:
  - Frame aborts immediately; outputs go to reset values asynchronously.
  - No Done is produced for the aborted frame.
- Counter width: $clog2(NBYTES) bits; wraps naturally only via the explicit reload to 0.
- Gap counter: 4 bits.
- Assertions for the verifier:
  - Cout implies Vout.
  - Done implies Vout.
  - Cout and Done are never high together when NBYTES > 1.
  - Exactly NBYTES Vout cycles between consecutive Cout pulses, gap cycles excluded.

Decomposition:
- serdes_pkg holds BYTE_W and NBYTES defaults, the state enum (IDLE, SEND, GAP) and a frame-length constant. These are shared with the deserializer.
- Single module. Shift/count logic is small and no sub-module is natural.

Test Plan:
- Single word: reset, release, wait 2 cycles, drive s_valid with s_data = 0xA1B2C3D4 -> Dout A1, B2, C3, D4 on 4 consecutive cycles. Cout with A1, Done with D4; Vout 0 afterwards; s_ready 1 again next cycle.
- Back-to-back, IFG = 0: s_valid held with 0x11223344 then 0x55667788 -> 8 contiguous Vout cycles. Cout with 11 and 55; Done with 44 and 88; s_ready high only on the cycles carrying 44 and 88.
- IFG = 2: two words 0xDEADBEEF, 0x01020304 -> EF followed by 2 cycles of Vout = 0, Dout = 0; then 01 with Cout. s_ready = 1 only in the second gap cycle.
- Stall/hold: assert s_valid with 0xCAFEF00D during the cycle carrying byte 2 of a frame -> not accepted. Accepted at the last-byte edge; s_data changes after acceptance do not alter the emitted bytes.
- Reset mid-frame: assert rst_n low after the second byte of 0x0BADC0DE -> outputs 0 asynchronously, no Done. After release, s_ready 0 for one cycle, then a new word 0x12345678 serializes correctly.
- Reset values: hold rst_n low with s_valid = 1 -> s_ready, Vout, Cout, Done, busy, Dout all 0; no transfer is taken.
